// File: rtl/axi4_write_master.sv
// AXI4 full write master for the DMA datapath.
// Drains a first-word-fall-through FIFO into memory as INCR bursts that
// never cross a 4KB boundary, one burst outstanding at a time.
// Completion is flagged by a one-cycle o_write_done pulse.
// Any non-OKAY write response sets the sticky o_write_err.
module axi4_write_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_MAX_BURST_LEN    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    // transfer control
    input  logic                          i_start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [31:0]                   i_total_len,
    output logic                          o_write_done,
    output logic                          o_write_err,
    output logic                          o_busy,
    // data FIFO (first-word fall-through)
    input  logic                          i_fifo_empty,
    output logic                          o_fifo_pop,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_w_data,
    // AXI write address channel
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    // AXI write data channel
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    // AXI write response channel
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t                        state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;      // start address of the current burst
    logic [31:0]                   words_q;     // words still to be written, incl. current burst
    logic [7:0]                    awlen_q;
    logic [7:0]                    beat_cnt;
    logic                          awvalid_q;
    logic                          bready_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          err_q;

    logic [31:0]                   start_words;
    logic [8:0]                    start_beats;
    logic [8:0]                    cur_beats;
    logic [C_M_AXI_ADDR_WIDTH-1:0] next_addr;
    logic [31:0]                   next_words;
    logic [8:0]                    next_beats;
    logic                          w_hs;
    logic                          unused_len_lsbs;

    // Burst size: limited by remaining words, the max burst length and the
    // distance to the next 4KB page (address is word aligned, so >= 1 word).
    function automatic logic [8:0] calc_beats(input logic [C_M_AXI_ADDR_WIDTH-1:0] addr,
                                              input logic [31:0]                   words);
        logic [31:0] page_words;
        logic [31:0] beats;
        page_words = (32'd4096 - 32'(addr[11:0])) >> 2;
        beats      = (words < 32'(C_MAX_BURST_LEN)) ? words : 32'(C_MAX_BURST_LEN);
        beats      = (beats < page_words) ? beats : page_words;
        return 9'(beats);
    endfunction

    // Byte count is rounded down to whole words; the low two bits carry no meaning.
    assign unused_len_lsbs = ^i_total_len[1:0];

    // Next-burst arithmetic for both the start of a transfer and the B-response step.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        start_words = {2'b00, i_total_len[31:2]};
        start_beats = calc_beats(i_dst_addr, start_words);
        cur_beats   = {1'b0, awlen_q} + 9'd1;
        next_addr   = addr_q + C_M_AXI_ADDR_WIDTH'({cur_beats, 2'b00});
        next_words  = words_q - 32'(cur_beats);
        next_beats  = calc_beats(next_addr, next_words);
    end

    // Transfer FSM with all control outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            words_q   <= '0;
            awlen_q   <= '0;
            beat_cnt  <= '0;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        addr_q  <= i_dst_addr;
                        words_q <= start_words;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (start_words == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            awlen_q   <= 8'(start_beats - 9'd1);
                            awvalid_q <= 1'b1;
                            state     <= S_AW;
                        end
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        beat_cnt  <= '0;
                        state     <= S_W;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (m_axi_wlast) begin
                            bready_q <= 1'b1;
                            state    <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        err_q    <= err_q | (m_axi_bresp != 2'b00);
                        addr_q   <= next_addr;
                        words_q  <= next_words;
                        if (next_words == 32'd0) begin
                            state <= S_DONE;
                        end else begin
                            awlen_q   <= 8'(next_beats - 9'd1);
                            awvalid_q <= 1'b1;
                            state     <= S_AW;
                        end
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The data channel follows the FIFO head directly so a stall costs no extra cycle.
    assign m_axi_wvalid  = (state == S_W) & ~i_fifo_empty;
    assign m_axi_wlast   = (beat_cnt == awlen_q) & m_axi_wvalid;
    assign m_axi_wdata   = i_w_data;
    assign w_hs          = m_axi_wvalid & m_axi_wready;
    assign o_fifo_pop    = w_hs;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = awlen_q;
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_bready  = bready_q;

    assign o_write_done  = done_q;
    assign o_write_err   = err_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_axi4_write_master.sv
// Bench for axi4_write_master: a FIFO model and AXI slave model drive the
// DUT while a negedge monitor pops expected AW bursts, W beats and done
// pulses from scoreboard queues filled by the directed stimulus.
module tb_axi4_write_master;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } w_exp_t;

    logic        clk;
    logic        reset_n;
    logic        i_start;
    logic [31:0] i_dst_addr;
    logic [31:0] i_total_len;
    logic        o_write_done;
    logic        o_write_err;
    logic        o_busy;
    logic        i_fifo_empty;
    logic        o_fifo_pop;
    logic [31:0] i_w_data;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    axi4_write_master dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_start       (i_start),
        .i_dst_addr    (i_dst_addr),
        .i_total_len   (i_total_len),
        .o_write_done  (o_write_done),
        .o_write_err   (o_write_err),
        .o_busy        (o_busy),
        .i_fifo_empty  (i_fifo_empty),
        .o_fifo_pop    (o_fifo_pop),
        .i_w_data      (i_w_data),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    // scoreboard and models
    aw_exp_t     exp_aw[$];
    w_exp_t      exp_w[$];
    logic        exp_done_err[$];
    logic [31:0] fifo_q[$];
    logic [1:0]  resp_plan[$];

    int          n_checks = 0;
    int          n_passed = 0;
    int          pop_total = 0;
    int          aw_cnt = 0;
    int          wl_cnt = 0;
    int          b_pending = 0;
    int          aw_delay = 0;
    int          aw_wait = 0;
    logic [31:0] fill_val;
    logic [31:0] exp_val;
    logic        pop_now = 1'b0;
    logic        aw_hs = 1'b0;
    logic        b_hs = 1'b0;
    logic        b_inc = 1'b0;
    logic        prev_done = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic refresh_fifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_w_data     = (fifo_q.size() == 0) ? 32'hDEAD_BEEF : fifo_q[0];
    endtask

    task automatic set_base(input logic [31:0] base);
        fill_val = base;
        exp_val  = base;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(fill_val);
            fill_val = fill_val + 32'd1;
        end
        refresh_fifo();
    endtask

    // Expect one burst plus its beats, data continuing the running pattern.
    task automatic add_aw(input logic [31:0] addr, input logic [7:0] len);
        aw_exp_t a;
        w_exp_t  w;
        a.addr = addr;
        a.len  = len;
        exp_aw.push_back(a);
        for (int i = 0; i <= int'(len); i++) begin
            w.data = exp_val;
            w.last = (i == int'(len));
            exp_w.push_back(w);
            exp_val = exp_val + 32'd1;
        end
    endtask

    task automatic start(input logic [31:0] addr, input logic [31:0] len);
        @(posedge clk);
        #1;
        i_dst_addr  = addr;
        i_total_len = len;
        i_start     = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((exp_done_err.size() != 0 || exp_aw.size() != 0 || exp_w.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 64'(n < budget), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares every DUT presentation against the scoreboard heads.
    initial begin
        forever begin
            @(negedge clk);
            if (m_axi_awvalid) begin
                if (exp_aw.size() == 0) begin
                    check("aw_unexpected", 64'(m_axi_awvalid), 64'd0);
                end else begin
                    check("awaddr", 64'(m_axi_awaddr), 64'(exp_aw[0].addr));
                    check("awlen", 64'(m_axi_awlen), 64'(exp_aw[0].len));
                    if (m_axi_awready) begin
                        check("awsize_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'({3'b010, 2'b01}));
                        void'(exp_aw.pop_front());
                        aw_hs = 1'b1;
                        aw_cnt++;
                    end
                end
            end
            if (m_axi_wvalid) check("w_after_aw", 64'(aw_cnt), 64'(wl_cnt + 1));
            if (m_axi_wvalid && m_axi_wready) begin
                check("fifo_pop", 64'(o_fifo_pop), 64'd1);
                if (exp_w.size() == 0) begin
                    check("w_unexpected", 64'(m_axi_wvalid), 64'd0);
                end else begin
                    check("wdata_wlast_wstrb", {27'd0, m_axi_wstrb, m_axi_wlast, m_axi_wdata},
                          {27'd0, 4'hF, exp_w[0].last, exp_w[0].data});
                    void'(exp_w.pop_front());
                end
                pop_now = 1'b1;
                pop_total++;
                if (m_axi_wlast) begin
                    wl_cnt++;
                    b_inc = 1'b1;
                end
            end
            if (i_fifo_empty && o_busy)
                check("stall_quiet", 64'({m_axi_wvalid, m_axi_wlast, o_fifo_pop}), 64'd0);
            if (m_axi_bvalid && m_axi_bready) b_hs = 1'b1;
            if (o_write_done) begin
                if (exp_done_err.size() == 0) begin
                    check("done_unexpected", 64'(o_write_done), 64'd0);
                end else begin
                    check("done_err", 64'(o_write_err), 64'(exp_done_err[0]));
                    void'(exp_done_err.pop_front());
                end
            end
            if (prev_done) check("done_one_cycle", 64'(o_write_done), 64'd0);
            prev_done = o_write_done;
        end
    end

    // Slave and FIFO models: apply the handshakes the monitor saw, just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pop_now) begin
                void'(fifo_q.pop_front());
                pop_now = 1'b0;
            end
            if (b_hs) begin
                m_axi_bvalid = 1'b0;
                b_hs = 1'b0;
            end
            if (b_inc) begin
                b_pending++;
                b_inc = 1'b0;
            end
            if (b_pending > 0 && !m_axi_bvalid) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = (resp_plan.size() != 0) ? resp_plan.pop_front() : 2'b00;
                b_pending--;
            end
            if (aw_hs) begin
                aw_hs = 1'b0;
                aw_wait = 0;
                m_axi_awready = (aw_delay == 0);
            end else if (m_axi_awvalid && !m_axi_awready) begin
                aw_wait++;
                if (aw_wait >= aw_delay) m_axi_awready = 1'b1;
            end
            refresh_fifo();
        end
    end

    initial begin
        int n;
        int p0;
        reset_n       = 1'b0;
        i_start       = 1'b0;
        i_dst_addr    = '0;
        i_total_len   = '0;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        set_base(32'd0);
        refresh_fifo();

        // reset state
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                                 o_fifo_pop, o_write_done, o_write_err, o_busy}), 64'd0);
        check("reset_addr_len", 64'({m_axi_awaddr, m_axi_awlen}), 64'd0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // 64B: single 16-beat burst, awvalid one cycle after start
        set_base(32'd0);
        fill(16);
        add_aw(32'hC000_0000, 8'd15);
        exp_done_err.push_back(1'b0);
        start(32'hC000_0000, 32'd64);
        @(negedge clk);
        check("aw_latency", 64'(m_axi_awvalid), 64'd1);
        wait_idle("t64", 300);
        check("t64_fifo_left", 64'(fifo_q.size()), 64'd0);

        // 68B: 16 + 1 beats; one spare FIFO word must survive; mid-run start ignored
        set_base(32'd100);
        fill(18);
        add_aw(32'hC000_0000, 8'd15);
        add_aw(32'hC000_0040, 8'd0);
        exp_done_err.push_back(1'b0);
        p0 = pop_total;
        start(32'hC000_0000, 32'd68);
        repeat (3) @(posedge clk);
        start(32'h1234_0000, 32'd64);
        wait_idle("t68", 300);
        check("t68_pops", 64'(pop_total - p0), 64'd17);
        check("t68_fifo_left", 64'(fifo_q.size()), 64'd1);
        fifo_q.delete();
        refresh_fifo();

        // 32B just below a 4KB page: split at 0x1000
        set_base(32'd200);
        fill(8);
        add_aw(32'hC000_0FF8, 8'd1);
        add_aw(32'hC000_1000, 8'd5);
        exp_done_err.push_back(1'b0);
        start(32'hC000_0FF8, 32'd32);
        wait_idle("t4k", 300);

        // awready delayed 4 cycles, FIFO runs dry for 5 cycles mid-burst
        aw_delay = 4;
        m_axi_awready = 1'b0;
        set_base(32'd300);
        fill(3);
        add_aw(32'hC000_2000, 8'd7);
        exp_done_err.push_back(1'b0);
        start(32'hC000_2000, 32'd32);
        n = 0;
        while (fifo_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_drain_timeout", 64'(n < 200), 64'd1);
        p0 = pop_total;
        repeat (5) @(negedge clk);
        check("stall_pops", 64'(pop_total), 64'(p0));
        check("stall_busy", 64'(o_busy), 64'd1);
        @(posedge clk);
        #2;
        fill(5);
        wait_idle("tstall", 300);
        aw_delay = 0;
        m_axi_awready = 1'b1;

        // SLVERR on first of two bursts: transfer completes with sticky error
        set_base(32'd400);
        fill(32);
        resp_plan.push_back(2'b10);
        resp_plan.push_back(2'b00);
        add_aw(32'hC000_3000, 8'd15);
        add_aw(32'hC000_3040, 8'd15);
        exp_done_err.push_back(1'b1);
        start(32'hC000_3000, 32'd128);
        wait_idle("terr", 400);
        check("err_sticky", 64'(o_write_err), 64'd1);

        // next start clears the error
        set_base(32'd500);
        fill(1);
        add_aw(32'hC000_4000, 8'd0);
        exp_done_err.push_back(1'b0);
        start(32'hC000_4000, 32'd4);
        @(negedge clk);
        check("err_cleared", 64'(o_write_err), 64'd0);
        wait_idle("tclr", 200);

        // zero length: done two cycles after start, no AXI traffic
        exp_done_err.push_back(1'b0);
        start(32'hC000_5000, 32'd0);
        @(negedge clk);
        check("zero_len_c1", 64'({o_write_done, o_busy}), 64'({1'b0, 1'b1}));
        @(negedge clk);
        check("zero_len_c2", 64'(o_write_done), 64'd1);
        wait_idle("tzero", 50);

        // reset in the middle of the data phase
        set_base(32'd600);
        fill(16);
        add_aw(32'hC000_6000, 8'd15);
        p0 = pop_total;
        start(32'hC000_6000, 32'd64);
        n = 0;
        while (pop_total - p0 < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("midw_timeout", 64'(n < 200), 64'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midw_reset_ctrl", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                                      o_fifo_pop, o_write_done, o_write_err, o_busy}), 64'd0);
        exp_aw.delete();
        exp_w.delete();
        exp_done_err.delete();
        fifo_q.delete();
        resp_plan.delete();
        pop_now = 1'b0;
        aw_hs = 1'b0;
        b_hs = 1'b0;
        b_inc = 1'b0;
        b_pending = 0;
        aw_cnt = 0;
        wl_cnt = 0;
        m_axi_bvalid = 1'b0;
        refresh_fifo();
        repeat (3) @(posedge clk);
        #3;
        reset_n = 1'b1;
        fill(4);
        repeat (6) @(negedge clk);
        check("post_reset_quiet", 64'({m_axi_awvalid, o_busy, m_axi_awaddr}), 64'd0);
        fifo_q.delete();
        refresh_fifo();

        // recovery after the abort
        set_base(32'd700);
        fill(2);
        add_aw(32'hC000_7000, 8'd1);
        exp_done_err.push_back(1'b0);
        start(32'hC000_7000, 32'd8);
        wait_idle("trecover", 200);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
